// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings and the LSU state enum.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unsupported size encodings behave as word accesses, so they need word alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      default:     mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the addressed byte/half to bit 0 and extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one bus transaction per MW/MD request, stalling the core
// until the access finishes, fails alignment, or times out.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mw_i,
  input  logic              md_i,
  input  logic [2:0]        funct3_i,
  input  logic [3:0]        strb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output lsu_state_e        dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  // Bus handshake: a request is transferred on a cycle where mem_valid_o and mem_ready_i
  // are both high; address/we/strobe/data stay constant from the first valid cycle until
  // that transfer. Read data is taken on any cycle with mem_rvalid_i once the request has
  // been transferred (same cycle included).

  lsu_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_store;
  logic [2:0]       req_f3;
  logic [1:0]       req_alo;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      load_data;
  logic             start, start_mis, timeout, capture, complete, abort;

  lsu_load_align u_align (
    .rdata_i   (mem_rdata_i),
    .addr_lo_i (req_alo),
    .funct3_i  (req_f3),
    .data_o    (load_data)
  );

  assign start     = (state == ST_IDLE) && (mw_i || md_i);
  assign start_mis = is_misaligned(funct3_i, addr_i[1:0]);
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign capture   = !req_store && mem_rvalid_i &&
                     (((state == ST_REQ) && mem_ready_i) || (state == ST_RESP));
  assign complete  = ((state == ST_REQ) && mem_ready_i && req_store) || capture;
  assign abort     = ((state == ST_REQ) || (state == ST_RESP)) && timeout && !complete;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mw_i || md_i) state_nxt = start_mis ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (mem_ready_i)  state_nxt = (req_store || mem_rvalid_i) ? ST_DONE : ST_RESP;
        else if (timeout) state_nxt = ST_DONE;
      end
      ST_RESP: if (mem_rvalid_i || timeout) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = (state == ST_REQ);
    done_o      = (state == ST_DONE);
    err_o       = (state == ST_DONE) && err_q;
    stall_o     = (mw_i || md_i) && (state != ST_DONE);
    rdata_o     = rdata_q;
    dbg_state_o = state;
  end

  // The request is frozen on IDLE exit so later input changes cannot disturb the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      req_store   <= 1'b0;
      req_f3      <= '0;
      req_alo     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
    end else if (start) begin
      cnt         <= '0;
      req_store   <= mw_i;
      req_f3      <= funct3_i;
      req_alo     <= addr_i[1:0];
      err_q       <= start_mis;
      rdata_q     <= '0;
      mem_we_o    <= mw_i;
      mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
      mem_wstrb_o <= mw_i ? strb_i : 4'b0000;
      mem_wdata_o <= wdata_i << {addr_i[1:0], 3'b000};
    end else if ((state == ST_REQ) || (state == ST_RESP)) begin
      cnt <= cnt + 1'b1;
      if (capture) rdata_q <= load_data;
      if (abort)   err_q   <= 1'b1;
    end
  end

endmodule
